ofmap_collector: RTL and testbench

Downstream stage for `acc_top`. It takes the fp16 result stream (`dout_valid`, `ofmap_out[15:0]`) and the `done` pulse, packs pairs of results into 32-bit words, and buffers them in a FIFO. The CPU drains the FIFO through a second ICB slave port, so the E203 core can read results without sampling the accelerator's output strobes directly.

---
 rtl/ofmap_collector.sv | 198 +++++++++++++++++++
 tb/tb_ofmap_collector.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ofmap_collector.sv
// ofmap_collector
//   Collects the fp16 result stream of acc_top, packs pairs of samples into
//   32-bit words (first sample in [15:0]) and queues them in a circular FIFO
//   that the CPU drains over an ICB slave port.
//
// Ports
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_dout_valid, i_ofmap_in   result strobe and fp16 sample
//   i_done                     accelerator finished (rising edge used)
//   i_icb_cmd_*/o_icb_cmd_ready   ICB command channel
//   o_icb_rsp_*/i_icb_rsp_ready   ICB response channel
//   o_irq                      done_seen & FIFO not empty (registered)
//
// Register map (byte offsets)
//   0x000 STATUS RO : [15:0] count, [16] empty, [17] full, [18] overflow,
//                     [19] done_seen, [20] half-word pending
//   0x004 CTRL   WO : bit0 flush, bit1 clear overflow (wmask[0] gates)
//   0x008 DATA   RO : read pops the head word
module ofmap_collector #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 12
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_dout_valid,
    input  logic [15:0] i_ofmap_in,
    input  logic        i_done,
    input  logic        i_icb_cmd_valid,
    output logic        o_icb_cmd_ready,
    input  logic        i_icb_cmd_read,
    input  logic [31:0] i_icb_cmd_addr,
    input  logic [31:0] i_icb_cmd_wdata,
    input  logic [3:0]  i_icb_cmd_wmask,
    output logic        o_icb_rsp_valid,
    input  logic        i_icb_rsp_ready,
    output logic [31:0] o_icb_rsp_rdata,
    output logic        o_icb_rsp_err,
    output logic        o_irq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] OFF_STATUS = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] OFF_CTRL   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] OFF_DATA   = ADDR_W'(8);

    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_pend_valid;
    logic [15:0]      r_pend_data;
    logic             r_ovf, r_done_seen, r_done_prev, r_irq;
    logic             r_rsp_valid, r_rsp_err;
    logic [31:0]      r_rsp_rdata;

    logic [ADDR_W-1:0] w_off;
    logic w_cmd_ready, w_cmd_fire, w_is_status, w_is_ctrl, w_is_data;
    logic w_empty, w_full, w_err, w_pop, w_ctrl_wr, w_flush, w_clr_ovf;
    logic w_done_rise, w_push, w_push_ok, w_drop, w_pend_valid_next;
    logic [15:0] w_pend_data_next;
    logic [31:0] w_push_data, w_status, w_rdata;
    logic w_unused;

    // Upper address bits, upper write data and upper byte enables are ignored.
    assign w_unused = ^{i_icb_cmd_addr[31:ADDR_W], i_icb_cmd_wdata[31:2], i_icb_cmd_wmask[3:1]};

    assign w_off       = i_icb_cmd_addr[ADDR_W-1:0];
    assign w_cmd_ready = ~r_rsp_valid | i_icb_rsp_ready;
    assign w_cmd_fire  = i_icb_cmd_valid & w_cmd_ready;
    assign w_is_status = (w_off == OFF_STATUS);
    assign w_is_ctrl   = (w_off == OFF_CTRL);
    assign w_is_data   = (w_off == OFF_DATA);
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FULL_CNT);
    assign w_done_rise = i_done & ~r_done_prev;

    assign w_status = {11'd0, r_pend_valid, r_done_seen, r_ovf, w_full, w_empty, 16'(r_count)};

    // Command decode: errors have no side effects, so pop/ctrl are gated by !err.
    always_comb begin
        w_err = (i_icb_cmd_read  & w_is_data & w_empty)
              | (~i_icb_cmd_read & (w_is_status | w_is_data))
              | (i_icb_cmd_read  & w_is_ctrl)
              | ~(w_is_status | w_is_ctrl | w_is_data);
        w_pop     = w_cmd_fire & i_icb_cmd_read & w_is_data & ~w_empty;
        w_ctrl_wr = w_cmd_fire & ~i_icb_cmd_read & w_is_ctrl & i_icb_cmd_wmask[0];
        w_flush   = w_ctrl_wr & i_icb_cmd_wdata[0];
        w_clr_ovf = w_ctrl_wr & i_icb_cmd_wdata[1];
        w_rdata   = 32'd0;
        if (!w_err && i_icb_cmd_read) begin
            if (w_is_status)
                w_rdata = w_status;
            else if (w_is_data)
                w_rdata = r_mem[r_rd_ptr];   // head taken before any same-cycle write
        end
    end

    // Packing: the sample is paired first, then the done edge pads a leftover half.
    // At most one word can be produced per cycle.
    always_comb begin
        w_push            = 1'b0;
        w_push_data       = 32'd0;
        w_pend_valid_next = r_pend_valid;
        w_pend_data_next  = r_pend_data;
        if (i_dout_valid) begin
            if (r_pend_valid) begin
                w_push            = 1'b1;
                w_push_data       = {i_ofmap_in, r_pend_data};
                w_pend_valid_next = 1'b0;
                w_pend_data_next  = 16'd0;
            end else begin
                w_pend_valid_next = 1'b1;
                w_pend_data_next  = i_ofmap_in;
            end
        end
        if (w_done_rise && w_pend_valid_next) begin
            w_push            = 1'b1;
            w_push_data       = {16'h0000, w_pend_data_next};
            w_pend_valid_next = 1'b0;
            w_pend_data_next  = 16'd0;
        end
        if (w_flush) begin
            w_push            = 1'b0;
            w_pend_valid_next = 1'b0;
            w_pend_data_next  = 16'd0;
        end
    end

    // A push into a full FIFO only succeeds if the head leaves in the same cycle.
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & ~w_push_ok;

    always_ff @(posedge i_clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= 16'd0;
            r_ovf        <= 1'b0;
            r_done_seen  <= 1'b0;
            r_done_prev  <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            r_done_prev  <= i_done;
            r_pend_valid <= w_pend_valid_next;
            r_pend_data  <= w_pend_data_next;
            r_irq        <= r_done_seen & ~w_empty;
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push_ok)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
            end
            if (w_drop)
                r_ovf <= 1'b1;
            else if (w_clr_ovf)
                r_ovf <= 1'b0;
            if (w_flush)
                r_done_seen <= 1'b0;
            else if (w_done_rise)
                r_done_seen <= 1'b1;
        end
    end

    // Single-slot response register; data/err are cleared once consumed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else if (w_cmd_fire) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rdata;
            r_rsp_err   <= w_err;
        end else if (i_icb_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end
    end

    assign o_icb_cmd_ready = w_cmd_ready;
    assign o_icb_rsp_valid = r_rsp_valid;
    assign o_icb_rsp_rdata = r_rsp_rdata;
    assign o_icb_rsp_err   = r_rsp_err;
    assign o_irq           = r_irq;
endmodule

// File: tb/tb_ofmap_collector.sv
module tb_ofmap_collector;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dout_valid = 1'b0;
    logic [15:0] ofmap_in = 16'd0;
    logic        done = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_read = 1'b0;
    logic [31:0] cmd_addr = 32'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic [3:0]  cmd_wmask = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        irq;

    int total = 0;
    int bad = 0;

    ofmap_collector #(.DEPTH(64), .ADDR_W(12)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_dout_valid(dout_valid), .i_ofmap_in(ofmap_in), .i_done(done),
        .i_icb_cmd_valid(cmd_valid), .o_icb_cmd_ready(cmd_ready),
        .i_icb_cmd_read(cmd_read), .i_icb_cmd_addr(cmd_addr),
        .i_icb_cmd_wdata(cmd_wdata), .i_icb_cmd_wmask(cmd_wmask),
        .o_icb_rsp_valid(rsp_valid), .i_icb_rsp_ready(rsp_ready),
        .o_icb_rsp_rdata(rsp_rdata), .o_icb_rsp_err(rsp_err), .o_irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          kind;      // 0 sample, 1 done pulse, 2 ICB
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [15:0] smp;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t vs(logic [15:0] s, logic ei);
        vec_t v = '{0, 1'b0, 32'd0, 32'd0, 4'd0, s, 32'd0, 1'b0, ei};
        return v;
    endfunction
    function automatic vec_t vd(logic ei);
        vec_t v = '{1, 1'b0, 32'd0, 32'd0, 4'd0, 16'd0, 32'd0, 1'b0, ei};
        return v;
    endfunction
    function automatic vec_t vr(logic [31:0] a, logic [31:0] er, logic ee, logic ei);
        vec_t v = '{2, 1'b1, a, 32'd0, 4'd0, 16'd0, er, ee, ei};
        return v;
    endfunction
    function automatic vec_t vw(logic [31:0] a, logic [31:0] wd, logic [3:0] wm, logic ee, logic ei);
        vec_t v = '{2, 1'b0, a, wd, wm, 16'd0, 32'd0, ee, ei};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic sample(input logic [15:0] s);
        @(negedge clk); dout_valid = 1'b1; ofmap_in = s;
        @(negedge clk); dout_valid = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk); done = 1'b1;
        @(negedge clk); done = 1'b0;
    endtask

    // One ICB transaction with rsp_ready held high; response sampled 1ns after accept.
    task automatic icb(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] wm, input logic [31:0] er, input logic ee,
                       input string name);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_wdata = wd; cmd_wmask = wm;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk({name, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, ".rdata"}, rsp_rdata, er);
        chk({name, ".err"}, 32'(rsp_err), 32'(ee));
        $display("icb %s rd=%0b addr=%h rdata=%h err=%0b", name, rd, a, rsp_rdata, rsp_err);
    endtask

    initial begin
        // Pairing, odd count with done, errors and CTRL behaviour.
        tbl.push_back(vs(16'h3C00, 1'b0));
        tbl.push_back(vs(16'h4000, 1'b0));
        tbl.push_back(vr(32'h000, 32'h0000_0001, 1'b0, 1'b0));
        tbl.push_back(vr(32'h008, 32'h4000_3C00, 1'b0, 1'b0));
        tbl.push_back(vr(32'h000, 32'h0001_0000, 1'b0, 1'b0));
        tbl.push_back(vs(16'h1111, 1'b0));
        tbl.push_back(vr(32'h000, 32'h0011_0000, 1'b0, 1'b0));
        tbl.push_back(vs(16'h2222, 1'b0));
        tbl.push_back(vs(16'h3333, 1'b0));
        tbl.push_back(vr(32'h000, 32'h0010_0001, 1'b0, 1'b0));
        tbl.push_back(vd(1'b1));
        tbl.push_back(vr(32'h000, 32'h0008_0002, 1'b0, 1'b1));
        tbl.push_back(vr(32'h008, 32'h2222_1111, 1'b0, 1'b1));
        tbl.push_back(vr(32'h008, 32'h0000_3333, 1'b0, 1'b0));
        tbl.push_back(vr(32'h000, 32'h0009_0000, 1'b0, 1'b0));
        tbl.push_back(vr(32'h008, 32'h0000_0000, 1'b1, 1'b0));
        tbl.push_back(vr(32'h000, 32'h0009_0000, 1'b0, 1'b0));
        tbl.push_back(vw(32'h000, 32'h0000_0003, 4'hF, 1'b1, 1'b0));
        tbl.push_back(vw(32'h008, 32'h0000_0003, 4'hF, 1'b1, 1'b0));
        tbl.push_back(vr(32'h004, 32'h0000_0000, 1'b1, 1'b0));
        tbl.push_back(vr(32'h00C, 32'h0000_0000, 1'b1, 1'b0));
        tbl.push_back(vr(32'h1000, 32'h0009_0000, 1'b0, 1'b0));
        tbl.push_back(vw(32'h004, 32'h0000_0001, 4'h0, 1'b0, 1'b0));
        tbl.push_back(vr(32'h000, 32'h0009_0000, 1'b0, 1'b0));
        tbl.push_back(vw(32'h004, 32'h0000_0001, 4'h1, 1'b0, 1'b0));
        tbl.push_back(vr(32'h000, 32'h0001_0000, 1'b0, 1'b0));

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.rdata", rsp_rdata, 32'd0);
        chk("reset.err", 32'(rsp_err), 32'd0);
        chk("reset.irq", 32'(irq), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            case (tbl[i].kind)
                0: begin
                    sample(tbl[i].smp);
                    $display("sample %s data=%h", nm, tbl[i].smp);
                end
                1: begin
                    pulse_done();
                    $display("done %s", nm);
                end
                default: icb(tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].wmask,
                             tbl[i].exp_rdata, tbl[i].exp_err, nm);
            endcase
            repeat (2) @(negedge clk);
            chk({nm, ".irq"}, 32'(irq), 32'(tbl[i].exp_irq));
        end

        // Overflow: 130 samples -> 65 words, the last one dropped.
        for (int i = 0; i < 130; i++) begin
            @(negedge clk); dout_valid = 1'b1; ofmap_in = 16'(i);
        end
        @(negedge clk); dout_valid = 1'b0;
        icb(1'b1, 32'h000, 32'd0, 4'd0, 32'h0006_0040, 1'b0, "ovf.status");
        icb(1'b0, 32'h004, 32'h2, 4'h1, 32'd0, 1'b0, "ovf.clear");
        icb(1'b1, 32'h000, 32'd0, 4'd0, 32'h0002_0040, 1'b0, "ovf.status2");

        // Full FIFO: pop in the same cycle as a completing push.
        sample(16'hAAAA);
        @(negedge clk);
        dout_valid = 1'b1; ofmap_in = 16'hBBBB;
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h008;
        @(posedge clk); #1;
        dout_valid = 1'b0; cmd_valid = 1'b0;
        chk("simul.rdata", rsp_rdata, 32'h0001_0000);
        chk("simul.err", 32'(rsp_err), 32'd0);
        $display("icb simul pop rdata=%h err=%0b", rsp_rdata, rsp_err);
        icb(1'b1, 32'h000, 32'd0, 4'd0, 32'h0002_0040, 1'b0, "simul.status");
        for (int k = 1; k < 64; k++)
            icb(1'b1, 32'h008, 32'd0, 4'd0, {16'(2*k+1), 16'(2*k)}, 1'b0,
                $sformatf("drain%0d", k));
        icb(1'b1, 32'h008, 32'd0, 4'd0, 32'hBBBB_AAAA, 1'b0, "drain.last");
        icb(1'b1, 32'h000, 32'd0, 4'd0, 32'h0001_0000, 1'b0, "drain.status");

        // Backpressure: response held stable, no new accept while stalled.
        sample(16'h5555);
        sample(16'h6666);
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h008;
        @(posedge clk); #1;
        cmd_addr = 32'h000;
        chk("bp.rsp_valid", 32'(rsp_valid), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("bp.cmd_ready%0d", c), 32'(cmd_ready), 32'd0);
            chk($sformatf("bp.rdata%0d", c), rsp_rdata, 32'h6666_5555);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("bp.next_valid", 32'(rsp_valid), 32'd1);
        chk("bp.next_rdata", rsp_rdata, 32'h0001_0000);
        $display("icb backpressure next rdata=%h", rsp_rdata);
        @(posedge clk); #1;
        chk("bp.idle", 32'(rsp_valid), 32'd0);

        // Flush in the same cycle as a completing sample.
        sample(16'h7001);
        sample(16'h7002);
        sample(16'h7003);
        @(negedge clk);
        dout_valid = 1'b1; ofmap_in = 16'h7004;
        cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 32'h004; cmd_wdata = 32'h1; cmd_wmask = 4'h1;
        @(posedge clk); #1;
        dout_valid = 1'b0; cmd_valid = 1'b0;
        chk("flush.err", 32'(rsp_err), 32'd0);
        icb(1'b1, 32'h000, 32'd0, 4'd0, 32'h0001_0000, 1'b0, "flush.status");

        // done edge together with a sample that completes a pair: no padding.
        sample(16'h8001);
        @(negedge clk);
        dout_valid = 1'b1; ofmap_in = 16'h8002; done = 1'b1;
        @(negedge clk);
        dout_valid = 1'b0; done = 1'b0;
        icb(1'b1, 32'h000, 32'd0, 4'd0, 32'h0008_0001, 1'b0, "donepair.status");
        icb(1'b1, 32'h008, 32'd0, 4'd0, 32'h8002_8001, 1'b0, "donepair.data");
        // done edge together with a lone sample: padded word.
        @(negedge clk);
        dout_valid = 1'b1; ofmap_in = 16'h9001; done = 1'b1;
        @(negedge clk);
        dout_valid = 1'b0; done = 1'b0;
        icb(1'b1, 32'h000, 32'd0, 4'd0, 32'h0008_0001, 1'b0, "donepad.status");
        icb(1'b1, 32'h008, 32'd0, 4'd0, 32'h0000_9001, 1'b0, "donepad.data");

        // Async reset while a response is waiting.
        sample(16'hC001);
        sample(16'hC002);
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h000;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("rst.pre_valid", 32'(rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst.rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; rsp_ready = 1'b1;
        icb(1'b1, 32'h000, 32'd0, 4'd0, 32'h0001_0000, 1'b0, "rst.status");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
